// File: rtl/mat_tile_file.sv
// Accumulator tile register file: forwarded operand read, prioritised tile updates,
// and a snapshot-based row streamer for matrix stores.
module mat_tile_file #(
  parameter int NUM_TILES = 4,
  parameter int IDX_W     = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [127:0]       rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [127:0]       wr_data,
  input  logic               zero_en,
  input  logic [IDX_W-1:0]   zero_idx,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_idx,
  input  logic [1:0]         ld_row,
  input  logic [31:0]        ld_data,
  input  logic               st_req,
  input  logic [IDX_W-1:0]   st_idx,
  output logic               st_ack,
  output logic               busy,
  output logic               st_valid,
  input  logic               st_ready,
  output logic [31:0]        st_data,
  output logic [1:0]         st_row,
  output logic               st_last
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_STREAM = 1'b1;

  logic [127:0] tiles_q [NUM_TILES];
  logic [127:0] tiles_d [NUM_TILES];

  logic         state_q, state_d;
  logic [1:0]   row_q, row_d;
  logic [127:0] shadow_q, shadow_d;
  logic         ack_q, ack_d;

  // Next-edge tile values; the same view feeds rd_data and the stream snapshot.
  always_comb begin
    for (int t = 0; t < NUM_TILES; t++) begin
      tiles_d[t] = tiles_q[t];
      if (zero_en && (zero_idx == IDX_W'(t))) begin
        tiles_d[t] = '0;
      end else if (wr_en && (wr_idx == IDX_W'(t))) begin
        tiles_d[t] = wr_data;
      end else if (ld_en && (ld_idx == IDX_W'(t))) begin
        tiles_d[t][{ld_row, 5'd0} +: 32] = ld_data;
      end
    end
  end

  assign rd_data = tiles_d[rd_idx];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (st_req) begin
          shadow_d = tiles_d[st_idx];
          row_d    = 2'd0;
          state_d  = ST_STREAM;
          ack_d    = 1'b1;
        end
      end
      default: begin
        if (st_ready) begin
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        tiles_q[t] <= '0;
      end
      state_q  <= ST_IDLE;
      row_q    <= 2'd0;
      shadow_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_TILES; t++) begin
        tiles_q[t] <= tiles_d[t];
      end
      state_q  <= state_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
    end
  end

  assign st_ack   = ack_q;
  assign st_valid = (state_q == ST_STREAM);
  assign busy     = (state_q == ST_STREAM);
  assign st_row   = row_q;
  assign st_data  = shadow_q[{row_q, 5'd0} +: 32];
  assign st_last  = st_valid && (row_q == 2'd3);

endmodule

// File: tb/tb_mat_tile_file.sv
// Directed bench for mat_tile_file: forwarding, update priority, streaming with
// backpressure, snapshot isolation, busy ignore and reset abort.
module tb_mat_tile_file;

  logic         clk;
  logic         rstn;
  logic [1:0]   rd_idx;
  logic [127:0] rd_data;
  logic         wr_en;
  logic [1:0]   wr_idx;
  logic [127:0] wr_data;
  logic         zero_en;
  logic [1:0]   zero_idx;
  logic         ld_en;
  logic [1:0]   ld_idx;
  logic [1:0]   ld_row;
  logic [31:0]  ld_data;
  logic         st_req;
  logic [1:0]   st_idx;
  logic         st_ack;
  logic         busy;
  logic         st_valid;
  logic         st_ready;
  logic [31:0]  st_data;
  logic [1:0]   st_row;
  logic         st_last;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [31:0] exp_row [4];

  mat_tile_file #(.NUM_TILES(4), .IDX_W(2)) dut (
    .clk(clk), .rstn(rstn),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .zero_en(zero_en), .zero_idx(zero_idx),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_row(ld_row), .ld_data(ld_data),
    .st_req(st_req), .st_idx(st_idx), .st_ack(st_ack), .busy(busy),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_row(st_row), .st_last(st_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Entered in the first STREAM cycle, after the ack has been checked.
  task automatic run_stream(input bit toggle, input bit do_wr);
    int beat = 0;
    bit have_held = 0;
    logic [31:0] held = '0;
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      st_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (do_wr) begin
        wr_en   = (cyc == 0);
        wr_idx  = 2'd0;
        wr_data = '1;
      end
      #1;
      if (cyc > 0) check("ack_single_pulse", st_ack, 0);
      check("valid_in_stream", st_valid, 1);
      check("busy_in_stream", busy, 1);
      if (have_held) check("data_held", st_data, held);
      if (st_ready) begin
        check("beat_data", st_data, exp_row[beat]);
        check("beat_row", st_row, beat);
        check("beat_last", st_last, beat == 3);
        beat++;
        have_held = 0;
      end else begin
        held = st_data;
        have_held = 1;
      end
      tick();
    end
    check("stream_beats", beat, 4);
    st_ready = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rstn = 0; rd_idx = 0; wr_en = 0; wr_idx = 0; wr_data = '0;
    zero_en = 0; zero_idx = 0; ld_en = 0; ld_idx = 0; ld_row = 0; ld_data = '0;
    st_req = 0; st_idx = 0; st_ready = 0;

    // Reset state
    #12;
    for (int t = 0; t < 4; t++) begin
      rd_idx = 2'(t);
      #1;
      check("reset_tile", rd_data, 0);
    end
    check("reset_valid", st_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_ack", st_ack, 0);
    check("reset_last", st_last, 0);
    check("reset_row", st_row, 0);
    check("reset_data", st_data, 0);
    rstn = 1;
    tick();

    // Write forwarding
    wr_en = 1; wr_idx = 2; wr_data = 128'h0102030405060708090a0b0c0d0e0f10; rd_idx = 2;
    #1 check("wr_forward", rd_data, 128'h0102030405060708090a0b0c0d0e0f10);
    tick();
    wr_en = 0;
    #1 check("wr_persist", rd_data, 128'h0102030405060708090a0b0c0d0e0f10);

    // Priority: zero beats wr beats ld on one tile
    wr_en = 1; wr_idx = 1; wr_data = {4{32'h55555555}}; rd_idx = 1;
    tick();
    wr_en = 0;
    #1 check("tile1_prefill", rd_data, {4{32'h55555555}});
    zero_en = 1; zero_idx = 1;
    wr_en = 1; wr_idx = 1; wr_data = {4{32'hAAAAAAAA}};
    ld_en = 1; ld_idx = 1; ld_row = 0; ld_data = 32'h12345678;
    #1 check("prio_forward_zero", rd_data, 0);
    tick();
    zero_en = 0; wr_en = 0; ld_en = 0;
    #1 check("prio_zero", rd_data, 0);
    wr_en = 1; wr_idx = 1; wr_data = {4{32'hAAAAAAAA}};
    ld_en = 1; ld_idx = 1; ld_row = 2; ld_data = 32'h12345678;
    #1 check("prio_wr_over_ld", rd_data, {4{32'hAAAAAAAA}});
    wr_en = 0; ld_en = 0;
    #1 check("prio_no_commit", rd_data, 0);

    ld_en = 1; ld_idx = 1; ld_row = 3; ld_data = 32'hDEADBEEF;
    #1 check("ld_forward", rd_data, {32'hDEADBEEF, 96'h0});
    tick();
    ld_en = 0;
    #1 check("ld_row3", rd_data, {32'hDEADBEEF, 96'h0});

    // Updates to different tiles in one cycle both apply
    wr_en = 1; wr_idx = 3; wr_data = 128'hF0E0D0C0B0A090807060504030201000;
    ld_en = 1; ld_idx = 1; ld_row = 0; ld_data = 32'hCAFEF00D;
    tick();
    wr_en = 0; ld_en = 0;
    #1 check("multi_ld_tile1", rd_data, {32'hDEADBEEF, 64'h0, 32'hCAFEF00D});
    rd_idx = 3;
    #1 check("multi_wr_tile3", rd_data, 128'hF0E0D0C0B0A090807060504030201000);

    // Fill tile 0 row by row
    for (int r = 0; r < 4; r++) begin
      ld_en = 1; ld_idx = 0; ld_row = 2'(r); ld_data = {4{4'(r + 1), 4'(r + 1)}};
      tick();
    end
    ld_en = 0; rd_idx = 0;
    #1 check("tile0_rows", rd_data, 128'h44444444333333332222222211111111);

    // Stream tile 0 with toggling ready
    exp_row[0] = 32'h11111111; exp_row[1] = 32'h22222222;
    exp_row[2] = 32'h33333333; exp_row[3] = 32'h44444444;
    st_req = 1; st_idx = 0;
    #1 check("idle_no_ack", st_ack, 0);
    tick();
    #1 check("ackA", st_ack, 1);
    check("busyA", busy, 1);
    st_req = 0;
    run_stream(1, 0);
    #1 check("busy_clear_A", busy, 0);
    check("valid_clear_A", st_valid, 0);
    check("ack_clear_A", st_ack, 0);

    // Snapshot isolation; tile 1 requested throughout, accepted after last beat
    st_req = 1; st_idx = 0;
    tick();
    #1 check("ackB", st_ack, 1);
    st_idx = 1;
    run_stream(0, 1);
    #1 check("busy_clear_B", busy, 0);
    check("no_ack_while_busy", st_ack, 0);
    tick();
    #1 check("ack_back_to_back", st_ack, 1);
    check("busy_back_to_back", busy, 1);
    st_req = 0;
    exp_row[0] = 32'hCAFEF00D; exp_row[1] = 32'h0;
    exp_row[2] = 32'h0;        exp_row[3] = 32'hDEADBEEF;
    run_stream(1, 0);
    rd_idx = 0;
    #1 check("tile0_after_isolation", rd_data, '1);

    // Reset mid-stream
    st_req = 1; st_idx = 0;
    tick();
    st_req = 0; st_ready = 1;
    tick();
    st_ready = 1;
    rstn = 0;
    #1 check("rst_mid_valid", st_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ack", st_ack, 0);
    for (int t = 0; t < 4; t++) begin
      rd_idx = 2'(t);
      #1;
      check("rst_mid_tile", rd_data, 0);
    end
    tick();
    rstn = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1 check("no_beats_after_reset", st_valid, 0);
    end
    st_ready = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
